dual_priority_encode: RTL
=========================

DUAL_PRIORITY_ENCODE -- requirements
Module: dual_priority_encode

Interface
REQ-001 The block SHALL have no parameters; the request width is fixed at 12 and the code width at 4.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req  input  12  request vector; bit k maps to code k+1.
REQ-005 i_valid  input  1  upstream has a request vector.
REQ-006 o_ready  output  1  block can accept a request vector (IDLE only).
REQ-007 o_valid  output  1  result available.
REQ-008 i_ready  input  1  downstream accepts result.
REQ-009 o_first  output  4  code of highest set bit; 0 = none.
REQ-010 o_second  output  4  code of second-highest set bit; 0 = none.

Function
REQ-011 Code mapping SHALL be: bit k set -> code k+1 (bit0 -> 1, bit11 -> 12); code 0 = no bit; codes 13-15 SHALL never be produced.
REQ-012 FSM states SHALL be IDLE, SCAN, DONE.
REQ-013 IDLE: o_ready=1; on an edge with i_valid&&o_ready, i_req SHALL be captured into an internal register, the scan index SHALL be set to 11, and the FSM SHALL go to SCAN (acceptance edge).
REQ-014 SCAN: each edge SHALL examine one captured bit, index 11 down to 0; the first set bit SHALL load o_first and the next set bit SHALL load o_second.
REQ-015 Without early exit, the edge examining bit 0 SHALL move the FSM to DONE; o_valid SHALL rise exactly 12 edges after the acceptance edge.
REQ-016 i_req and i_valid SHALL be ignored outside IDLE; o_ready=0 in SCAN and DONE.
REQ-017 DONE: o_valid=1; o_first and o_second SHALL be held stable until i_ready=1.
REQ-018 On an edge with o_valid&&i_ready, the FSM SHALL go to IDLE with o_valid=0 and o_ready=1 from that edge; back-to-back acceptance in DONE SHALL NOT occur.
REQ-019 o_first and o_second SHALL be cleared to 0 on the acceptance edge, so an all-zero vector yields 0/0 and a single-bit vector yields first=k+1, second=0.

Reset
REQ-020 Reset assertion SHALL force, without waiting for a clock edge: FSM=IDLE, o_valid=0, o_ready=1, o_first=0, o_second=0, scan index=0, captured vector=0.
REQ-021 Reset asserted mid-SCAN or in DONE SHALL abort the transaction; no partial result SHALL be presented after release.
REQ-022 After release, the first edge with i_valid=1 SHALL be accepted normally.

Configuration
REQ-023 Macro DUAL_PRIO_EARLY_EXIT_EN: when defined, the edge that loads o_second SHALL also move the FSM to DONE; latency is 12-j edges, where j is the bit index of the second-highest set bit.
REQ-024 When DUAL_PRIO_EARLY_EXIT_EN is undefined, latency SHALL always be 12 edges; results SHALL be identical in both builds.

Structure
REQ-025 Package dual_priority_pkg SHALL hold the state enum type, REQ_W=12, CODE_W=4, and CODE_NONE=0.
REQ-026 No sub-module SHALL be used; the FSM, scan counter and capture register SHALL be in dual_priority_encode.

Verification
REQ-027 i_req=0x000 -> o_first=0, o_second=0, o_valid 12 edges after acceptance (both builds).
REQ-028 i_req=0x801 -> o_first=12, o_second=1, latency 12 (both builds).
REQ-029 i_req=0x00C -> o_first=4, o_second=3; latency 12 without the macro, 10 with DUAL_PRIO_EARLY_EXIT_EN.
REQ-030 i_req=0x040 -> o_first=7, o_second=0; i_req changed to 0xFFF during SCAN -> result unchanged.
REQ-031 i_ready held low 5 cycles in DONE with i_valid=1 -> outputs stable, o_ready=0, no new capture; i_ready=1 -> IDLE next edge.
REQ-032 i_rst_n pulsed low at scan index 6 -> immediate o_valid=0, o_first=0, o_second=0, o_ready=1; following i_req=0x300 -> o_first=10, o_second=9.

Source files
------------

// File: rtl/dual_priority_pkg.sv
// Shared types and constants for the dual priority encoder.
// The optional early-exit build is selected with DUAL_PRIO_EARLY_EXIT_EN.
package dual_priority_pkg;

    localparam int REQ_W  = 12;
    localparam int CODE_W = 4;
    localparam int IDX_W  = 4;

    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit k of the request vector is reported as code k+1, leaving 0 for "none".
    function automatic logic [CODE_W-1:0] to_code(input logic [IDX_W-1:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/dual_priority_encode.sv
// Sequential encoder reporting the codes of the highest and second-highest set request bits.
// Define DUAL_PRIO_EARLY_EXIT_EN to finish the scan as soon as the second bit is found.
module dual_priority_encode
    import dual_priority_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REQ_W-1:0]  i_req,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CODE_W-1:0] o_first,
    output logic [CODE_W-1:0] o_second
);

    // Handshake: a transfer happens on any rising edge where valid and ready are
    // both high. Upstream is accepted only in IDLE; the result is offered in DONE
    // and held until downstream takes it.

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [REQ_W-1:0]   cap, cap_n;
    logic [CODE_W-1:0]  first, first_n;
    logic [CODE_W-1:0]  second, second_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cap    <= '0;
            first  <= CODE_NONE;
            second <= CODE_NONE;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cap    <= cap_n;
            first  <= first_n;
            second <= second_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cap_n    = cap;
        first_n  = first;
        second_n = second;
        unique case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    cap_n    = i_req;
                    idx_n    = 4'(REQ_W - 1);
                    first_n  = CODE_NONE;
                    second_n = CODE_NONE;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A loaded code is never zero, so CODE_NONE marks a free slot.
                if (cap[idx]) begin
                    if (first == CODE_NONE) begin
                        first_n = to_code(idx);
                    end else if (second == CODE_NONE) begin
                        second_n = to_code(idx);
`ifdef DUAL_PRIO_EARLY_EXIT_EN
                        state_n  = ST_DONE;
`endif
                    end
                end
                if (idx == '0) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx - 4'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_ready  = (state == ST_IDLE);
    assign o_valid  = (state == ST_DONE);
    assign o_first  = first;
    assign o_second = second;

endmodule
